// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline stage: valid/ready handshake, 2-entry skid buffer, flush,
// and a WB result mux that is evaluated as an entry is loaded into the main register.
module mem_wb_skid_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned RSRC_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc_plus4,
    input  logic [XLEN-1:0]   in_read_data,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_reg_write,
    input  logic [RSRC_W-1:0] in_result_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc_plus4,
    output logic [XLEN-1:0]   out_read_data,
    output logic [XLEN-1:0]   out_alu_result,
    output logic [RD_W-1:0]   out_rd,
    output logic [RSRC_W-1:0] out_result_src,
    output logic [XLEN-1:0]   out_result,
    output logic              out_reg_write,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc_plus4;
        logic [XLEN-1:0]   read_data;
        logic [XLEN-1:0]   alu_result;
        logic [RD_W-1:0]   rd;
        logic              reg_write;
        logic [RSRC_W-1:0] result_src;
    } entry_t;

    state_t          state_q, state_d;
    entry_t          main_q, main_d, skid_q, skid_d, in_entry;
    logic [XLEN-1:0] result_q, result_d;
    logic            valid_q, valid_d;
    logic            ready_q, ready_d;
    logic            wr_q, wr_d;
    logic [1:0]      occ_q, occ_d;
    logic            accept, consume;

    // WB value selection; undefined encodings read as zero
    function automatic logic [XLEN-1:0] select_result(input entry_t e);
        case (e.result_src)
            RSRC_W'(0): select_result = e.alu_result;
            RSRC_W'(1): select_result = e.read_data;
            RSRC_W'(2): select_result = e.pc_plus4;
            default:    select_result = '0;
        endcase
    endfunction

    assign in_entry = {in_pc_plus4, in_read_data, in_alu_result, in_rd, in_reg_write, in_result_src};
    assign accept   = in_valid & ready_q;
    assign consume  = valid_q & out_ready;

    // Next state and next contents of main/skid
    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        result_d = result_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d  = ONE;
                    main_d   = in_entry;
                    result_d = select_result(in_entry);
                end
            end
            ONE: begin
                if (accept && consume) begin
                    main_d   = in_entry;
                    result_d = select_result(in_entry);
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_entry;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    state_d  = ONE;
                    main_d   = skid_q;
                    result_d = select_result(skid_q);
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops the incoming entry; held data fields keep their last value
        if (flush_i) begin
            state_d  = EMPTY;
            main_d   = main_q;
            skid_d   = skid_q;
            result_d = result_q;
        end
    end

    // Output flags derived from the next state so they are registered with it
    always_comb begin
        valid_d = (state_d != EMPTY);
        ready_d = (state_d != FULL);
        wr_d    = valid_d & main_d.reg_write & (main_d.rd != '0);
        case (state_d)
            ONE:     occ_d = 2'd1;
            FULL:    occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            wr_q     <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            wr_q     <= wr_d;
            occ_q    <= occ_d;
        end
    end

    assign in_ready       = ready_q;
    assign out_valid      = valid_q;
    assign out_pc_plus4   = main_q.pc_plus4;
    assign out_read_data  = main_q.read_data;
    assign out_alu_result = main_q.alu_result;
    assign out_rd         = main_q.rd;
    assign out_result_src = main_q.result_src;
    assign out_result     = result_q;
    assign out_reg_write  = wr_q;
    assign occupancy      = occ_q;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Self-checking bench for mem_wb_skid_stage: vector table, queue scoreboard,
// and directed back-pressure / flush / reset sequences.
module tb_mem_wb_skid_stage;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned RSRC_W = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush_i = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc_plus4 = '0;
    logic [XLEN-1:0]   in_read_data = '0;
    logic [XLEN-1:0]   in_alu_result = '0;
    logic [RD_W-1:0]   in_rd = '0;
    logic              in_reg_write = 1'b0;
    logic [RSRC_W-1:0] in_result_src = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [XLEN-1:0]   out_pc_plus4, out_read_data, out_alu_result, out_result;
    logic [RD_W-1:0]   out_rd;
    logic [RSRC_W-1:0] out_result_src;
    logic              out_reg_write;
    logic [1:0]        occupancy;

    always #5 clk = ~clk;

    mem_wb_skid_stage #(.XLEN(XLEN), .RD_W(RD_W), .RSRC_W(RSRC_W)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc_plus4(in_pc_plus4), .in_read_data(in_read_data),
        .in_alu_result(in_alu_result), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_result_src(in_result_src),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc_plus4(out_pc_plus4), .out_read_data(out_read_data),
        .out_alu_result(out_alu_result), .out_rd(out_rd),
        .out_result_src(out_result_src), .out_result(out_result),
        .out_reg_write(out_reg_write), .occupancy(occupancy)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  src;
    } ent_t;

    typedef struct {
        ent_t        e;
        logic [31:0] exp_result;
        logic        exp_wr;
    } vec_t;

    ent_t        q[$];
    logic [31:0] popped[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] model_result(ent_t e);
        case (e.src)
            2'd0:    return e.alu;
            2'd1:    return e.rdata;
            2'd2:    return e.pc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic ent_t mk(logic [31:0] pc, logic [31:0] rdata, logic [31:0] alu,
                                logic [4:0] rd, logic rw, logic [1:0] src);
        ent_t e;
        e.pc = pc; e.rdata = rdata; e.alu = alu; e.rd = rd; e.rw = rw; e.src = src;
        return e;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(ent_t e);
        in_pc_plus4   = e.pc;
        in_read_data  = e.rdata;
        in_alu_result = e.alu;
        in_rd         = e.rd;
        in_reg_write  = e.rw;
        in_result_src = e.src;
    endtask

    // Scoreboard: checks held state against the model queue, then applies the coming edge
    always @(negedge clk) begin
        int   sz;
        ent_t h;
        if (mon_en) begin
            sz = q.size();
            chk("sb_occupancy", 32'(occupancy), 32'(sz));
            chk("sb_in_ready", 32'(in_ready), 32'(sz != 2));
            chk("sb_out_valid", 32'(out_valid), 32'(sz != 0));
            if (sz != 0) begin
                h = q[0];
                chk("sb_out_result", out_result, model_result(h));
                chk("sb_out_alu", out_alu_result, h.alu);
                chk("sb_out_rd", 32'(out_rd), 32'(h.rd));
                chk("sb_out_reg_write", 32'(out_reg_write), 32'(h.rw && (h.rd != 5'd0)));
            end else begin
                chk("sb_idle_reg_write", 32'(out_reg_write), 32'h0);
            end
            if (!reset) begin
                q.delete();
            end else begin
                if (sz != 0 && out_ready) begin
                    h = q.pop_front();
                    popped.push_back(h.alu);
                end
                if (flush_i) q.delete();
                else if (in_valid && sz != 2) q.push_back(mk(in_pc_plus4, in_read_data, in_alu_result,
                                                             in_rd, in_reg_write, in_result_src));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[7];
        ent_t        ea, eb, ec;
        logic [31:0] tags[3];
        bit          acc;

        vecs[0] = '{e: mk(32'h0, 32'h0, 32'h0000_0010, 5'd5, 1'b1, 2'd0), exp_result: 32'h0000_0010, exp_wr: 1'b1};
        vecs[1] = '{e: mk(32'h104, 32'hDEAD_BEEF, 32'h0000_0020, 5'd6, 1'b1, 2'd1), exp_result: 32'hDEAD_BEEF, exp_wr: 1'b1};
        vecs[2] = '{e: mk(32'h104, 32'hDEAD_BEEF, 32'h0000_0020, 5'd7, 1'b1, 2'd2), exp_result: 32'h0000_0104, exp_wr: 1'b1};
        vecs[3] = '{e: mk(32'h104, 32'hDEAD_BEEF, 32'h0000_0020, 5'd8, 1'b1, 2'd3), exp_result: 32'h0000_0000, exp_wr: 1'b1};
        vecs[4] = '{e: mk(32'h200, 32'h1234_5678, 32'h0000_0055, 5'd0, 1'b1, 2'd0), exp_result: 32'h0000_0055, exp_wr: 1'b0};
        vecs[5] = '{e: mk(32'h300, 32'hCAFE_F00D, 32'h0000_0066, 5'd9, 1'b0, 2'd1), exp_result: 32'hCAFE_F00D, exp_wr: 1'b0};
        vecs[6] = '{e: mk(32'hFFFF_FFFC, 32'h0, 32'hAAAA_5555, 5'd31, 1'b1, 2'd2), exp_result: 32'hFFFF_FFFC, exp_wr: 1'b1};

        // Reset held low for two edges
        reset = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_alu", out_alu_result, 32'h0);
        chk("rst_out_read_data", out_read_data, 32'h0);
        chk("rst_out_pc_plus4", out_pc_plus4, 32'h0);
        chk("rst_out_rd", 32'(out_rd), 32'h0);
        chk("rst_out_result_src", 32'(out_result_src), 32'h0);
        chk("rst_out_reg_write", 32'(out_reg_write), 32'h0);
        mon_en = 1'b1;

        // Single-entry vectors: one-cycle latency, then drain
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].e);
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            chk("vec_out_valid", 32'(out_valid), 32'h1);
            chk("vec_out_result", out_result, vecs[i].exp_result);
            chk("vec_out_reg_write", 32'(out_reg_write), 32'(vecs[i].exp_wr));
            chk("vec_out_rd", 32'(out_rd), 32'(vecs[i].e.rd));
            cycle();
            chk("vec_drained_valid", 32'(out_valid), 32'h0);
            chk("vec_drained_reg_write", 32'(out_reg_write), 32'h0);
        end

        // Back-pressure with three back-to-back entries
        ea = mk(32'h1004, 32'h11, 32'hA000_0001, 5'd1, 1'b1, 2'd0);
        eb = mk(32'h1008, 32'h22, 32'hB000_0002, 5'd2, 1'b1, 2'd1);
        ec = mk(32'h100C, 32'h33, 32'hC000_0003, 5'd3, 1'b1, 2'd2);
        tags[0] = ea.alu; tags[1] = eb.alu; tags[2] = ec.alu;
        popped.delete();
        out_ready = 1'b0;
        drive(ea); in_valid = 1'b1; cycle();
        drive(eb); cycle();
        drive(ec); cycle(); cycle();
        chk("bp_occupancy", 32'(occupancy), 32'h2);
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        chk("bp_main_is_a", out_alu_result, ea.alu);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) begin
            if (in_ready) acc = 1'b1;
            cycle();
        end
        chk("bp_c_accepted", 32'(acc), 32'h1);
        in_valid = 1'b0;
        for (int k = 0; k < 8 && out_valid; k++) cycle();
        chk("bp_drained", 32'(out_valid), 32'h0);
        chk("bp_pop_count", popped.size(), 32'd3);
        for (int k = 0; k < popped.size() && k < 3; k++) chk("bp_order", popped[k], tags[k]);

        // Flush in FULL together with a new offer
        out_ready = 1'b0;
        drive(mk(32'h2004, 32'h44, 32'hD000_0004, 5'd4, 1'b1, 2'd0)); in_valid = 1'b1; cycle();
        drive(mk(32'h2008, 32'h55, 32'hD000_0005, 5'd5, 1'b1, 2'd0)); cycle();
        chk("fl_full", 32'(occupancy), 32'h2);
        popped.delete();
        drive(mk(32'h200C, 32'h66, 32'hEEEE_0006, 5'd6, 1'b1, 2'd0));
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        in_valid = 1'b0;
        chk("fl_occupancy", 32'(occupancy), 32'h0);
        chk("fl_out_valid", 32'(out_valid), 32'h0);
        chk("fl_in_ready", 32'(in_ready), 32'h1);
        chk("fl_reg_write", 32'(out_reg_write), 32'h0);
        out_ready = 1'b1;
        cycle(); cycle(); cycle();
        chk("fl_nothing_appears", 32'(out_valid), 32'h0);
        chk("fl_no_pops", popped.size(), 32'd0);

        // Flush coinciding with a consume still counts the consume
        out_ready = 1'b0;
        drive(mk(32'h3004, 32'h77, 32'hF000_0007, 5'd7, 1'b1, 2'd1)); in_valid = 1'b1; cycle();
        in_valid = 1'b0;
        popped.delete();
        out_ready = 1'b1;
        flush_i = 1'b1;
        cycle();
        flush_i = 1'b0;
        chk("flc_pop_count", popped.size(), 32'd1);
        chk("flc_out_valid", 32'(out_valid), 32'h0);

        // Reset while FULL with an offer pending
        out_ready = 1'b0;
        drive(mk(32'h4004, 32'h88, 32'h9000_0008, 5'd8, 1'b1, 2'd1)); in_valid = 1'b1; cycle();
        drive(mk(32'h4008, 32'h99, 32'h9000_0009, 5'd9, 1'b1, 2'd2)); cycle();
        chk("rf_full", 32'(occupancy), 32'h2);
        drive(mk(32'h400C, 32'hAA, 32'h9000_000A, 5'd10, 1'b1, 2'd0));
        reset = 1'b0;
        flush_i = 1'b1;
        out_ready = 1'b1;
        cycle();
        reset = 1'b1;
        flush_i = 1'b0;
        in_valid = 1'b0;
        chk("rf_occupancy", 32'(occupancy), 32'h0);
        chk("rf_out_valid", 32'(out_valid), 32'h0);
        chk("rf_in_ready", 32'(in_ready), 32'h1);
        chk("rf_out_result", out_result, 32'h0);
        chk("rf_out_alu", out_alu_result, 32'h0);
        chk("rf_out_rd", 32'(out_rd), 32'h0);
        cycle(); cycle();
        chk("rf_stays_empty", 32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
